// File: rtl/flow_ctrl_if.sv
// Config/probe and FIFO-bank bundle for the flow-control FSM.
// The master side drives thresholds, occupancy and error pulses; the slave side reports state and flags.
interface flow_ctrl_if #(
  parameter int NUM_FIFOS = 8,
  parameter int CNT_W     = 4
);
  logic                       init;
  logic [CNT_W-1:0]           umbral_bajo;
  logic [CNT_W-1:0]           umbral_alto;
  logic [NUM_FIFOS*CNT_W-1:0] fifo_count;
  logic [NUM_FIFOS-1:0]       fifo_error;
  logic [2:0]                 state;
  logic                       idle;
  logic                       active;
  logic                       error;
  logic [CNT_W-1:0]           bajo_q;
  logic [CNT_W-1:0]           alto_q;
  logic [NUM_FIFOS-1:0]       almost_empty;
  logic [NUM_FIFOS-1:0]       almost_full;
  logic                       pause;
  logic [NUM_FIFOS-1:0]       err_fifo;
  logic                       cfg_err;

  modport master (
    output init, umbral_bajo, umbral_alto, fifo_count, fifo_error,
    input  state, idle, active, error, bajo_q, alto_q,
           almost_empty, almost_full, pause, err_fifo, cfg_err
  );

  modport slave (
    input  init, umbral_bajo, umbral_alto, fifo_count, fifo_error,
    output state, idle, active, error, bajo_q, alto_q,
           almost_empty, almost_full, pause, err_fifo, cfg_err
  );
endinterface

// File: rtl/flow_ctrl_fsm_param.sv
// Flow-control FSM for a bank of NUM_FIFOS FIFOs: threshold capture, IDLE/ACTIVE tracking,
// per-FIFO almost_empty/almost_full flags, global pause and a sticky ERROR trap.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_RESET  | post-reset, everything cleared; leaves on first edge
// S_INIT   | thresholds follow umbral_* while init=1; validated on exit
// S_IDLE   | all FIFOs empty
// S_ACTIVE | at least one FIFO holds data
// S_ERROR  | FIFO or threshold error trapped; only reset leaves
module flow_ctrl_fsm_param #(
  parameter int NUM_FIFOS = 8,
  parameter int CNT_W     = 4
) (
  input  logic           clk,
  input  logic           reset,
  flow_ctrl_if.slave     bus
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     bajo_q, alto_q;
  logic [NUM_FIFOS-1:0] ae_q, af_q, ae_d, af_d;
  logic [NUM_FIFOS-1:0] err_fifo_q;
  logic                 cfg_err_q;
  logic                 load_thr;
  logic                 cfg_set;
  logic                 any_count;
  logic                 any_err;

  assign any_count = |bus.fifo_count;
  assign any_err   = |bus.fifo_error;

  always_comb begin
    state_d  = state_q;
    load_thr = 1'b0;
    cfg_set  = 1'b0;
    case (state_q)
      S_RESET: state_d = S_INIT;
      S_INIT: begin
        if (any_err) begin
          state_d = S_ERROR;
        end else if (bus.init) begin
          load_thr = 1'b1;
        end else if (bajo_q > alto_q) begin
          state_d = S_ERROR;
          cfg_set = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        if (any_err)        state_d = S_ERROR;
        else if (bus.init)  state_d = S_INIT;
        else if (any_count) state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (any_err)         state_d = S_ERROR;
        else if (bus.init)   state_d = S_INIT;
        else if (!any_count) state_d = S_IDLE;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_RESET;
    endcase
  end

  // Flags are gated by the state being entered, so they read 0 whenever state is RESET/INIT/ERROR.
  always_comb begin
    ae_d = '0;
    af_d = '0;
    if (state_d == S_IDLE || state_d == S_ACTIVE) begin
      for (int i = 0; i < NUM_FIFOS; i++) begin
        ae_d[i] = (bus.fifo_count[i*CNT_W +: CNT_W] <= bajo_q);
        af_d[i] = (bus.fifo_count[i*CNT_W +: CNT_W] >= alto_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_RESET;
      bajo_q     <= '0;
      alto_q     <= '0;
      ae_q       <= '0;
      af_q       <= '0;
      err_fifo_q <= '0;
      cfg_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ae_q    <= ae_d;
      af_q    <= af_d;
      if (load_thr) begin
        bajo_q <= bus.umbral_bajo;
        alto_q <= bus.umbral_alto;
      end
      if (state_q != S_RESET) err_fifo_q <= err_fifo_q | bus.fifo_error;
      if (cfg_set) cfg_err_q <= 1'b1;
    end
  end

  assign bus.state        = state_q;
  assign bus.idle         = (state_q == S_IDLE);
  assign bus.active       = (state_q == S_ACTIVE);
  assign bus.error        = (state_q == S_ERROR);
  assign bus.bajo_q       = bajo_q;
  assign bus.alto_q       = alto_q;
  assign bus.almost_empty = ae_q;
  assign bus.almost_full  = af_q;
  assign bus.pause        = |af_q;
  assign bus.err_fifo     = err_fifo_q;
  assign bus.cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_flow_ctrl_fsm_param.sv
// Directed bench for flow_ctrl_fsm_param: reset, threshold load, IDLE/ACTIVE tracking,
// flag boundaries, error trapping and reset recovery.
module tb_flow_ctrl_fsm_param;
  localparam int NF = 8;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  flow_ctrl_if #(.NUM_FIFOS(NF), .CNT_W(CW)) bus ();

  flow_ctrl_fsm_param #(.NUM_FIFOS(NF), .CNT_W(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset           = 1'b1;
    bus.init        = 1'b0;
    bus.umbral_bajo = '0;
    bus.umbral_alto = '0;
    bus.fifo_count  = '0;
    bus.fifo_error  = '0;
    step();
    step();
    check("rst_state", 32'(bus.state), 0);
    check("rst_flags", {bus.almost_empty, bus.almost_full}, 0);
    check("rst_thr", {bus.bajo_q, bus.alto_q}, 0);
    check("rst_err", {bus.err_fifo, bus.cfg_err, bus.idle, bus.active, bus.error, bus.pause}, 0);

    // Test 1: load bajo=2, alto=12
    reset = 1'b0; bus.init = 1'b1; bus.umbral_bajo = 4'd2; bus.umbral_alto = 4'd12;
    step();
    check("t1_init", 32'(bus.state), 1);
    check("t1_init_flags", {bus.almost_empty, bus.almost_full}, 0);
    step();
    check("t1_thr", {bus.bajo_q, bus.alto_q}, 32'h2C);
    bus.init = 1'b0;
    step();
    check("t1_idle", {bus.state, bus.idle}, {3'd2, 1'b1});
    check("t1_idle_ae", 32'(bus.almost_empty), 32'hFF);

    // Test 2: fifo 3 at 5 sits between thresholds
    bus.fifo_count = 32'h0000_5000;
    step();
    check("t2_active", {bus.state, bus.active}, {3'd3, 1'b1});
    step();
    check("t2_ae", 32'(bus.almost_empty), 32'hF7);
    check("t2_af", 32'(bus.almost_full), 0);
    bus.fifo_count = '0;
    step();
    check("t2_back_idle", 32'(bus.state), 2);

    // Test 3: high then low boundary on fifo 0
    bus.fifo_count = 32'h0000_000C;
    step();
    check("t3_full", {bus.almost_full, bus.pause}, {8'h01, 1'b1});
    check("t3_full_ae", 32'(bus.almost_empty), 32'hFE);
    bus.fifo_count = 32'h0000_0002;
    step();
    check("t3_empty", {bus.almost_empty, bus.almost_full, bus.pause}, {8'hFF, 8'h00, 1'b0});
    check("t3_state", 32'(bus.state), 3);

    // Test 4: FIFO 5 error traps, init ignored, reset recovers
    bus.fifo_error = 8'h20;
    step();
    check("t4_error", {bus.state, bus.error, bus.err_fifo}, {3'd4, 1'b1, 8'h20});
    check("t4_flags", {bus.almost_empty, bus.almost_full}, 0);
    bus.fifo_error = '0; bus.init = 1'b1;
    step();
    check("t4_sticky", {bus.state, bus.err_fifo}, {3'd4, 8'h20});
    reset = 1'b1; bus.init = 1'b0; bus.fifo_count = '0;
    step();
    check("t4_reset", {bus.state, bus.err_fifo, bus.bajo_q, bus.alto_q, bus.error}, 0);

    // Test 5: inverted thresholds, then equal thresholds
    reset = 1'b0; bus.init = 1'b1; bus.umbral_bajo = 4'd9; bus.umbral_alto = 4'd3;
    step();
    step();
    check("t5_thr_bad", {bus.bajo_q, bus.alto_q}, 32'h93);
    bus.init = 1'b0;
    step();
    check("t5_cfg_err", {bus.state, bus.cfg_err}, {3'd4, 1'b1});
    reset = 1'b1;
    step();
    check("t5_cfg_clr", 32'(bus.cfg_err), 0);
    reset = 1'b0; bus.init = 1'b1; bus.umbral_bajo = 4'd7; bus.umbral_alto = 4'd7;
    step();
    step();
    bus.init = 1'b0;
    step();
    check("t5_eq_idle", {bus.state, bus.cfg_err}, {3'd2, 1'b0});
    bus.fifo_count = 32'h0000_0700;
    step();
    check("t5_both", {bus.almost_empty, bus.almost_full, bus.pause}, {8'hFF, 8'h04, 1'b1});

    // Test 6: reset mid-ACTIVE with almost_full set
    reset = 1'b1;
    step();
    check("t6_reset", {bus.state, bus.almost_empty, bus.almost_full, bus.pause, bus.active}, 0);

    // Simultaneous events: counts + init -> INIT; error + init -> ERROR
    reset = 1'b0; bus.fifo_count = '0; bus.init = 1'b1;
    bus.umbral_bajo = 4'd2; bus.umbral_alto = 4'd12;
    step();
    step();
    bus.init = 1'b0;
    step();
    check("sim_idle", 32'(bus.state), 2);
    bus.init = 1'b1; bus.fifo_count = 32'h0030_0000;
    step();
    check("sim_cnt_init", 32'(bus.state), 1);
    bus.fifo_error = 8'h01;
    step();
    check("sim_err_init", {bus.state, bus.err_fifo}, {3'd4, 8'h01});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
